// File: rtl/br_pkg.sv
// Shared types and error-bit positions for the branch resolve path.
package br_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;
  localparam int unsigned ERR_PCM = 2;

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction FIFO with synchronous clear; full/empty derived from an explicit count.
module pred_fifo
  import br_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t wdata,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  pred_entry_t           mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so push+pop at full is accepted.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks fetched predictions against EXE outcomes, trains the predictor and redirects fetch.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  input  logic                pred_taken,
  input  logic [31:0]         pred_target,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic                ex_taken,
  input  logic [31:0]         ex_target,
  input  logic                flush,
  output logic                update,
  output logic                actual_taken,
  output logic                mispredict,
  output logic [31:0]         redirect_pc,
  output logic                q_full,
  output logic                q_empty,
  output logic [2:0]          err_sticky,
  output logic [CNT_BITS-1:0] br_count,
  output logic [CNT_BITS-1:0] mp_count
);

  pred_entry_t         head, head_eff, wdata;
  logic                mp_cond, q_clear, ovf, unf, pcm;
  logic                update_q, actual_taken_q, mispredict_q;
  logic [31:0]         redirect_pc_q;
  logic [2:0]          err_q;
  logic [CNT_BITS-1:0] br_q, mp_q;

  assign wdata = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (pred_valid),
    .pop     (ex_valid),
    .clear   (q_clear),
    .wdata   (wdata),
    .head    (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_comb begin
    // Resolving with nothing queued compares against a not-taken prediction.
    head_eff = q_empty ? '{pc: ex_pc, taken: 1'b0, target: 32'h0} : head;
    mp_cond  = ex_valid & ((head_eff.taken != ex_taken) |
                           (ex_taken & (head_eff.target != ex_target)));
    q_clear  = flush | mp_cond;
    ovf      = pred_valid & q_full & ~ex_valid & ~flush;
    unf      = ex_valid & q_empty;
    pcm      = ex_valid & ~q_empty & (head.pc != ex_pc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update_q       <= 1'b0;
      actual_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      err_q          <= '0;
      br_q           <= '0;
      mp_q           <= '0;
    end else begin
      update_q       <= ex_valid;
      actual_taken_q <= ex_valid & ex_taken;
      mispredict_q   <= mp_cond & ~flush;
      if (ex_valid) redirect_pc_q <= ex_taken ? ex_target : ex_pc + 32'd4;
      err_q[ERR_OVF] <= err_q[ERR_OVF] | ovf;
      err_q[ERR_UNF] <= err_q[ERR_UNF] | unf;
      err_q[ERR_PCM] <= err_q[ERR_PCM] | pcm;
      if (ex_valid && br_q != '1) br_q <= br_q + CNT_BITS'(1);
      if (mp_cond && mp_q != '1)  mp_q <= mp_q + CNT_BITS'(1);
    end
  end

  assign update       = update_q;
  assign actual_taken = actual_taken_q;
  assign mispredict   = mispredict_q;
  assign redirect_pc  = redirect_pc_q;
  assign err_sticky   = err_q;
  assign br_count     = br_q;
  assign mp_count     = mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit against a small queue-based reference model.
module tb_branch_resolve_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk, reset_n;
  logic        pred_valid, pred_taken, ex_valid, ex_taken, flush;
  logic [31:0] pred_pc, pred_target, ex_pc, ex_target;
  logic        update, actual_taken, mispredict, q_full, q_empty;
  logic [31:0] redirect_pc, br_count, mp_count;
  logic [2:0]  err_sticky;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_BITS(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pred_valid   (pred_valid),
    .pred_pc      (pred_pc),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_taken     (ex_taken),
    .ex_target    (ex_target),
    .flush        (flush),
    .update       (update),
    .actual_taken (actual_taken),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .q_full       (q_full),
    .q_empty      (q_empty),
    .err_sticky   (err_sticky),
    .br_count     (br_count),
    .mp_count     (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    logic        taken;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  logic [2:0]  m_err;
  logic [31:0] m_br, m_mp;
  int          n_total, n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_err = '0;
    m_br  = '0;
    m_mp  = '0;
  endtask

  task automatic check_state();
    check_eq("q_empty", 32'(q_empty), 32'(mq.size() == 0));
    check_eq("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
    check_eq("err_sticky", 32'(err_sticky), 32'(m_err));
    check_eq("br_count", br_count, m_br);
    check_eq("mp_count", mp_count, m_mp);
  endtask

  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] ptg, input logic ev, input logic [31:0] epc,
                      input logic et, input logic [31:0] etg, input logic fl);
    ent_t h;
    exp_t e;
    logic mp, emp;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg; flush = fl;
    emp = (mq.size() == 0);
    h   = emp ? '{pc: epc, taken: 1'b0, target: 32'h0} : mq[0];
    mp  = ev && ((h.taken != et) || (et && h.target != etg));
    if (ev) begin
      e.taken = et;
      e.mp    = mp && !fl;
      e.rpc   = et ? etg : epc + 32'd4;
      sb.push_back(e);
      m_br++;
      if (mp) m_mp++;
      if (emp) m_err[1] = 1'b1;
      else if (h.pc != epc) m_err[2] = 1'b1;
    end
    if (fl || mp) mq.delete();
    else begin
      if (ev && !emp) void'(mq.pop_front());
      if (pv) begin
        if (mq.size() < DEPTH) mq.push_back('{pc: ppc, taken: pt, target: ptg});
        else m_err[0] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("update", 32'(update), 32'd1);
      check_eq("actual_taken", 32'(actual_taken), 32'(e.taken));
      check_eq("mispredict", 32'(mispredict), 32'(e.mp));
      if (e.mp) check_eq("redirect_pc", redirect_pc, e.rpc);
    end else begin
      check_eq("update_idle", 32'(update), 32'd0);
      check_eq("mispredict_idle", 32'(mispredict), 32'd0);
    end
    check_state();
  endtask

  task automatic push_p(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(1'b1, pc, t, tg, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, t, tg, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] epc, etg, ppc;
    logic        ev, et, pv;
    n_total = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; flush = 0;
    model_reset();
    #12;
    check_eq("rst_update", 32'(update), 32'd0);
    check_state();
    reset_n = 1'b1;

    // Correct prediction
    push_p(32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b1, 32'h200);
    step(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);

    // Direction miss kills the younger entry
    push_p(32'h104, 1'b0, 32'h0);
    push_p(32'h108, 1'b1, 32'h300);
    resolve(32'h104, 1'b1, 32'h180);

    // Target miss, then predicted-taken resolved not-taken
    push_p(32'h10C, 1'b1, 32'h400);
    resolve(32'h10C, 1'b1, 32'h404);
    push_p(32'h110, 1'b1, 32'h500);
    resolve(32'h110, 1'b0, 32'h0);

    // Fill, overflow, push+pop at full, then drain in order
    for (int i = 0; i < 4; i++) push_p(32'h200 + 32'(i * 4), i[0], 32'h600 + 32'(i * 16));
    push_p(32'h2F0, 1'b1, 32'h700);
    step(1'b1, 32'h210, 1'b1, 32'h640, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i < 5; i++) resolve(32'h200 + 32'(i * 4), i[0], 32'h600 + 32'(i * 16));

    // Resolve on empty queue, then flush with concurrent push and resolve
    resolve(32'h120, 1'b1, 32'h900);
    push_p(32'h130, 1'b0, 32'h0);
    push_p(32'h134, 1'b1, 32'h940);
    step(1'b1, 32'h138, 1'b1, 32'h950, 1'b1, 32'h130, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      pv  = ($urandom_range(0, 2) != 0);
      ppc = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      ev  = ($urandom_range(0, 2) == 0);
      epc = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0].pc : ppc;
      et  = 1'($urandom_range(0, 1));
      etg = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].target : 32'h3000;
      step(pv, ppc, 1'($urandom_range(0, 1)), 32'h3000, ev, epc, et, etg,
           ($urandom_range(0, 15) == 0));
    end

    // Async reset with an update pulse in flight
    for (int i = 0; i < 5; i++) push_p(32'h400 + 32'(i * 4), 1'b0, 32'h0);
    step(1'b0, 0, 0, 0, 1'b1, 32'h400, 1'b1, 32'h800, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_update", 32'(update), 32'd0);
    check_eq("async_mispredict", 32'(mispredict), 32'd0);
    check_state();
    #2;
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
